// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES block loader front-end.
package aes_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned AES_KEY_BITS    = 128;
    localparam int unsigned AES_BLOCK_BITS  = 8 * AES_BLOCK_BYTES;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        RELEASE
    } loader_state_t;

endpackage

// File: rtl/aes_block_loader_if.sv
// Plaintext byte stream with a valid/ready handshake.
interface aes_block_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/aes_block_loader_byte_packer.sv
// Shifts accepted bytes into a 128-bit block, first byte in bits [0:7];
// full pulses on the handshake that completes the block.
module aes_byte_packer
    import aes_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      accept,
    input  logic [7:0]                data,
    output logic [0:AES_BLOCK_BITS-1] block,
    output logic                      full
);

    localparam logic [3:0] LastByte = 4'(AES_BLOCK_BYTES - 1);

    logic [3:0]                byte_cnt_q;
    logic [0:AES_BLOCK_BITS-1] block_q;

    assign full  = accept && (byte_cnt_q == LastByte);
    assign block = block_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_q <= '0;
            block_q    <= '0;
        end else if (accept) begin
            block_q[8*byte_cnt_q +: 8] <= data;
            byte_cnt_q                 <= full ? 4'd0 : byte_cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// Front-end for the AES-128 core: packs bytes, holds the key, sequences
// start/valid_flag and guards the core with a watchdog.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    aes_block_loader_if.slave         stream,
    input  logic [0:AES_KEY_BITS-1]   key_in,
    input  logic                      key_we,
    output logic [0:AES_KEY_BITS-1]   key,
    output logic [0:AES_BLOCK_BITS-1] plain_text,
    output logic                      start,
    input  logic                      valid_flag,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [15:0]               blocks_done
);

    localparam logic [9:0] WdogLast = 10'(WDOG_CYCLES - 1);

    loader_state_t           state_q, state_d;
    logic [9:0]              wdog_q, wdog_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             blocks_q, blocks_d;
    logic [0:AES_KEY_BITS-1] key_q;
    logic                    accept;
    logic                    full;

    // Reset gating keeps ready low while the state register is still settling.
    assign stream.s_ready = (state_q == FILL) && !reset;
    assign accept         = stream.s_valid && stream.s_ready;

    aes_byte_packer u_packer (
        .clock  (clock),
        .reset  (reset),
        .accept (accept),
        .data   (stream.s_data),
        .block  (plain_text),
        .full   (full)
    );

    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        blocks_d  = blocks_q;
        unique case (state_q)
            FILL: begin
                if (full) begin
                    state_d = RUN;
                    wdog_d  = '0;
                end
            end
            RUN: begin
                wdog_d = wdog_q + 10'd1;
                // Completion takes priority over a coincident watchdog expiry.
                if (valid_flag) begin
                    blocks_d = blocks_q + 16'd1;
                    state_d  = RELEASE;
                end else if (wdog_q == WdogLast) begin
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (!valid_flag) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FILL;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            blocks_q  <= '0;
            key_q     <= '0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            blocks_q  <= blocks_d;
            // Key is frozen while the core is encrypting.
            if (key_we && (state_q != RUN)) begin
                key_q <= key_in;
            end
        end
    end

    assign key         = key_q;
    assign start       = (state_q == RUN);
    assign busy        = (state_q == RUN) || (state_q == RELEASE);
    assign timeout_err = timeout_q;
    assign blocks_done = blocks_q;

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Upstream front-end for the AES-128 `Encryption` core. It accepts plaintext as a byte stream over a valid/ready handshake and assembles 16 bytes into a 128-bit block. It holds the cipher key, drives `start`/`plain_text`/`key` into the core, and waits for `valid_flag`. A watchdog covers a core that never completes.

## Interface
Parameters:
- `WDOG_CYCLES`, default 64: maximum number of cycles in RUN before a timeout. Legal range 16..1023.

Ports:
- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_data`  in  8  plaintext byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `key_in`  in  [0:127]  new key value.
- `key_we`  in  1  write `key_in` into the key register.
- `key`  out  [0:127]  key to the core.
- `plain_text`  out  [0:127]  assembled block to the core.
- `start`  out  1  start level to the core.
- `valid_flag`  in  1  completion flag from the core.
- `busy`  out  1  high in RUN or RELEASE.
- `timeout_err`  out  1  sticky watchdog error.
- `blocks_done`  out  16  count of completed blocks; wraps.

## Operation
- Reset values: state FILL, `byte_cnt` 0, `key` 0, `plain_text` 0, `start` 0, `busy` 0, `timeout_err` 0, `blocks_done` 0, watchdog 0.
- `s_ready` = (state == FILL), decoded from the registered state only. It never depends on `s_valid`. It is 0 during the reset cycle.
- States:
  - FILL: each handshake (`s_valid & s_ready`) writes `s_data` into `plain_text[8*byte_cnt +: 8]`, counting bytes from 0. The first byte lands in bits [0:7] and the 16th in [120:127]. `byte_cnt` then increments. A handshake with `byte_cnt` == 15 resets `byte_cnt` to 0 and moves to RUN.
  - RUN: `start` = 1 and the watchdog increments each cycle.
    - If `valid_flag` is sampled high: increment `blocks_done` and go to RELEASE.
    - Else, if the watchdog equals `WDOG_CYCLES`-1: set `timeout_err` and go to RELEASE.
  - RELEASE: `start` = 0 and `s_ready` = 0. Go to FILL on the first edge where `valid_flag` is sampled low. This guarantees the core's flag drops before the next block can start.
- `key_we` updates `key` in FILL or RELEASE. In RUN it is ignored, so `key` is stable for the whole encryption.
- `plain_text` is stable in RUN and RELEASE. It may change in FILL; the core samples it only while `start` is high.
- In FILL, `valid_flag` is ignored.
- Bytes already accepted in FILL are never discarded. A partial block waits indefinitely.
- `timeout_err` clears only on `reset`.

## Timing
- Byte k is accepted at edge k. When the 16th handshake occurs at edge N, `start` = 1 and `busy` = 1 from edge N+1.
- `valid_flag` sampled high at edge M: from M+1, `start` = 0, `blocks_done` is +1 and the state is RELEASE. The earliest return to FILL is M+2.
- Watchdog: it is cleared on entering RUN. If `valid_flag` stays low, the timeout is taken at the edge where the count is `WDOG_CYCLES`-1, i.e. after `WDOG_CYCLES` RUN cycles.
- `valid_flag` high in the same cycle as watchdog expiry: success wins. `blocks_done` increments and `timeout_err` is unchanged.
- `key_we` on the same edge as the 16th byte: the new key is written and used for that block.
- `blocks_done` wraps from 0xFFFF to 0x0000.
- `reset` mid-RUN: the next edge gives reset values and `start` = 0. The block in progress is abandoned.

## Structure
- Shared `aes_pkg` holds:
  - `AES_BLOCK_BYTES` = 16;
  - `AES_KEY_BITS` = 128;
  - the `loader_state_t` enum {FILL, RUN, RELEASE}.
- The natural sub-module is `aes_byte_packer`: the byte shift-in register and `byte_cnt`, with a `full` pulse output.
- The FSM, watchdog, key register and counters stay in the top.

## Test plan
- Known-answer vector, integrated with `Encryption` (its `reset_n` tied to ~`reset`):
  - Stimulus: key = 0 via `key_we`; stream bytes 00 00 01 01 03 03 07 07 0f 0f 1f 1f 3f 3f 7f 7f.
  - Response: `plain_text` = 00000101030307070f0f1f1f3f3f7f7f; `start` rises one cycle after the 16th byte; `enc_data` = c7d12419489e3b6233a2c5a7f4563172; `blocks_done` = 1.
- Back-pressure: random `s_valid` gaps, plus bytes offered during RUN/RELEASE. Response: `s_ready` stays 0 outside FILL; no byte is lost or duplicated; `plain_text` is exact.
- Key lock: `key_we` with key_in = ff..ff pulsed mid-RUN. Response: `key` stays 0. The same pulse in RELEASE: `key` = ff..ff.
- Watchdog: stub core that never raises `valid_flag`, `WDOG_CYCLES` = 16. Response: `start` is high for exactly 16 cycles, then `timeout_err` = 1, `blocks_done` = 0, and FILL resumes.
- Simultaneous success and expiry: stub raises `valid_flag` on the expiry cycle. Response: `blocks_done` +1 and `timeout_err` stays 0.
- Reset mid-RUN: `reset` for one cycle. Response: all outputs at reset values next cycle; a new 16-byte block completes normally.
